predecode_queue: RTL and testbench
==================================

// Module: predecode_queue
// PURPOSE
//   Parametrised fetch-to-decode instruction queue with pre-decode. Sits between
//   the F2 pipeline register and the decode stage. Each RV32IM instruction is
//   classified and has its immediate generated on enqueue. The result is stored
//   alongside the instruction, so decode sees registered class bits at dequeue.
//   Absorbs fetch/decode rate mismatch and supports a single-cycle pipeline flush.
// PARAMETERS
//   DEPTH     4   queue entries; power of two, >= 2
//   ENABLE_M  1   1: OP with funct7=0000001 is legal; 0: flagged illegal
//   CNT_W     $clog2(DEPTH+1)  width of occupancy count (derived, do not override)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   flush      in   1      discard all entries (branch mispredict / trap)
//   in_valid   in   1      fetch presents an instruction
//   in_ready   out  1      queue can accept this cycle
//   in_pc      in   32     PC of in_inst
//   in_inst    in   32     raw instruction word
//   out_valid  out  1      head entry valid
//   out_ready  in   1      decode consumes head this cycle
//   out_pc     out  32     head PC
//   out_inst   out  32     head instruction word
//   out_imm    out  32     pre-generated immediate (I/S/B/U/J, shamt, CSR zimm)
//   out_cls    out  6      {illegal, is_csr, is_mem, is_mul, is_jump, is_branch}
//   count      out  CNT_W  current occupancy
// BEHAVIOUR
// - Storage and pointers
//   - Circular buffer; head/tail pointers log2(DEPTH) bits, wrap naturally.
//   - count tracks occupancy 0..DEPTH.
// - Handshakes
//   - Enqueue iff in_valid && in_ready.
//   - Dequeue iff out_valid && out_ready.
//   - in_ready = !full && !flush. No enqueue when full, even with a same-cycle
//     dequeue; this keeps in_ready free of any out_ready path.
//   - out_valid = (count != 0). out_* are the head entry's stored fields,
//     driven from registers; no combinational path from in_* to out_*.
//   - Latency: an instruction enqueued in cycle N is visible at out_* in N+1 at
//     the earliest. No bypass.
//   - Simultaneous enqueue and dequeue (not full): count unchanged, both
//     pointers advance.
// - Flush
//   - flush=1 at edge N: head=tail=0, count=0 after the edge.
//   - Enqueue/dequeue in that cycle are dropped; out_valid=0 in N+1.
//   - flush has priority over everything except reset.
// - Reset
//   - rst_n=0 at an edge: pointers=0, count=0, out_valid=0, all storage
//     fields=0 (so out_pc/out_inst/out_imm/out_cls read 0).
//   - in_ready reads 0 while rst_n=0.
//   - Reset mid-operation discards all entries.
// - Pre-decode (combinational on in_inst, result written with the entry)
//   - is_branch: opcode BRANCH.
//   - is_jump: opcode JAL or JALR.
//   - is_mem: opcode LOAD or STORE.
//   - is_csr: opcode SYSTEM and funct3 in {001,010,011,101,110,111}.
//   - is_mul: opcode OP, funct7=0000001, ENABLE_M=1.
//   - illegal is set for:
//     - opcode not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,SYSTEM};
//     - BRANCH funct3 in {010,011};
//     - LOAD funct3 in {011,110,111};
//     - STORE funct3 > 010;
//     - JALR funct3 != 000;
//     - OP funct7 not in {0000000,0100000,0000001};
//     - OP funct7=0100000 with funct3 not in {000,101};
//     - OP funct7=0000001 with ENABLE_M=0;
//     - OP_IMM slli with funct7 != 0, or srli/srai with funct7 not in
//       {0000000,0100000}.
//     When illegal=1, the other class bits are 0 and out_imm=0.
//   - Immediates use the RV32 formats:
//     - OP_IMM shifts: zero-extended shamt;
//     - SYSTEM: zero-extended inst[19:15];
//     - all others: sign-extended from inst[31].
// TESTING
// - Reset, then in_valid=1 with inst=0x00500093 (addi x1,x0,5), pc=0x100
//   -> next cycle out_valid=1, out_imm=5, out_cls=0, count=1.
// - Hold out_ready=0 and push DEPTH instructions -> in_ready=0 with count=DEPTH;
//   a 5th push is not accepted. Pop all -> values come out in FIFO order.
// - Full queue, in_valid=1 and out_ready=1 in the same cycle -> dequeue only,
//   count=DEPTH-1.
// - Continuous traffic for 3*DEPTH pushes and pops -> pointer wrap-around,
//   no loss or duplication.
// - Pre-decode checks:
//   - 0xFE000EE3 (beq, imm=-4) -> is_branch=1, out_imm=0xFFFFFFFC.
//   - 0x02208033 (mul) with ENABLE_M=0 -> illegal=1.
//   - 0x34202573 (csrrs) -> is_csr=1.
// - Queue holding 3 entries, assert flush together with an in_valid push
//   -> next cycle out_valid=0, count=0. Then rst_n=0 mid-traffic
//   -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/predecode_queue.sv
// Fetch-to-decode instruction queue with pre-decode on enqueue.
// Stores class bits and immediate next to each instruction.
module predecode_queue #(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_imm,
    output logic [5:0]       out_cls,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      imm_q  [DEPTH];
    logic [5:0]       cls_q  [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic        full;
    logic        do_enq;
    logic        do_deq;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [31:0] shamt, zimm;
    logic        ill, br, jmp, mem, csr, mul;
    logic [31:0] imm;
    logic [31:0] dec_imm;
    logic [5:0]  dec_cls;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = rst_n && !full && !flush;
    assign out_valid = (count_q != '0);
    assign do_enq    = in_valid && in_ready;
    assign do_deq    = out_valid && out_ready;

    assign out_pc    = pc_q[head_q];
    assign out_inst  = inst_q[head_q];
    assign out_imm   = imm_q[head_q];
    assign out_cls   = cls_q[head_q];
    assign count     = count_q;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign i_imm  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign s_imm  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign b_imm  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
    assign u_imm  = {in_inst[31:12], 12'h000};
    assign j_imm  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
    assign shamt  = {27'd0, in_inst[24:20]};
    assign zimm   = {27'd0, in_inst[19:15]};

    // Classify the incoming word and pick its immediate format.
    always_comb begin
        ill = 1'b0;
        br  = 1'b0;
        jmp = 1'b0;
        mem = 1'b0;
        csr = 1'b0;
        mul = 1'b0;
        imm = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm = u_imm;
            OPC_JAL: begin
                jmp = 1'b1;
                imm = j_imm;
            end
            OPC_JALR: begin
                jmp = 1'b1;
                imm = i_imm;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                br  = 1'b1;
                imm = b_imm;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                mem = 1'b1;
                imm = i_imm;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                mem = 1'b1;
                imm = s_imm;
                ill = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                if (f3 == 3'b001) begin
                    imm = shamt;
                    ill = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    imm = shamt;
                    ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end else begin
                    imm = i_imm;
                end
            end
            OPC_OP: begin
                case (f7)
                    7'b0000000: ill = 1'b0;
                    7'b0100000: ill = (f3 != 3'b000) && (f3 != 3'b101);
                    7'b0000001: begin
                        mul = (ENABLE_M != 0);
                        ill = (ENABLE_M == 0);
                    end
                    default:    ill = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                imm = zimm;
                csr = (f3 != 3'b000) && (f3 != 3'b100);
            end
            default: ill = 1'b1;
        endcase
        dec_cls = ill ? 6'b100000 : {1'b0, csr, mem, mul, jmp, br};
        dec_imm = ill ? '0 : imm;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_enq) tail_q <= tail_q + PTR_W'(1);
            if (do_deq) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    // Entry storage, written with the pre-decoded fields on enqueue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                imm_q[i]  <= '0;
                cls_q[i]  <= '0;
            end
        end else if (do_enq) begin
            pc_q[tail_q]   <= in_pc;
            inst_q[tail_q] <= in_inst;
            imm_q[tail_q]  <= dec_imm;
            cls_q[tail_q]  <= dec_cls;
        end
    end

endmodule

// File: tb/tb_predecode_queue.sv
// Bench for predecode_queue: directed vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_predecode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_inst = '0;
    logic          in_ready, out_valid;
    logic [31:0]   out_pc, out_inst, out_imm;
    logic [5:0]    out_cls;
    logic [CW-1:0] count;
    logic          m_in_ready, m_out_valid;
    logic [31:0]   m_out_pc, m_out_inst, m_out_imm;
    logic [5:0]    m_out_cls;
    logic [CW-1:0] m_count;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [5:0]  cls_m;
        logic [5:0]  cls_nom;
    } vec_t;

    always #5 clk = ~clk;

    predecode_queue #(.DEPTH(DEPTH), .ENABLE_M(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_imm(out_imm), .out_cls(out_cls), .count(count)
    );

    predecode_queue #(.DEPTH(DEPTH), .ENABLE_M(0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .out_inst(m_out_inst),
        .out_imm(m_out_imm), .out_cls(m_out_cls), .count(m_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        logic signed [31:0] t;
        t = $signed(v << (32 - n));
        return 32'(t >>> (32 - n));
    endfunction

    function automatic void ref_dec(input logic [31:0] i, input bit em,
                                    output logic [31:0] imm,
                                    output logic [5:0] cls);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ill, br, jp, mm, cs, mu;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        ill = 0; br = 0; jp = 0; mm = 0; cs = 0; mu = 0;
        imm = 0;
        case (op)
            7'h37, 7'h17: imm = {i[31:12], 12'h0};
            7'h6F: begin
                jp = 1;
                imm = sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            end
            7'h67: begin jp = 1; imm = sx({20'd0, i[31:20]}, 12); ill = (f3 != 0); end
            7'h63: begin
                br = 1;
                imm = sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
                ill = (f3 == 2) || (f3 == 3);
            end
            7'h03: begin
                mm = 1; imm = sx({20'd0, i[31:20]}, 12);
                ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
            end
            7'h23: begin
                mm = 1; imm = sx({20'd0, i[31:25], i[11:7]}, 12);
                ill = (f3 > 2);
            end
            7'h13: begin
                if (f3 == 1 || f3 == 5) imm = 32'(i[24:20]);
                else imm = sx({20'd0, i[31:20]}, 12);
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                if (f7 == 7'h20) ill = !(f3 == 0 || f3 == 5);
                else if (f7 == 7'h01) begin mu = em; ill = !em; end
                else if (f7 != 0) ill = 1;
            end
            7'h73: begin imm = 32'(i[19:15]); cs = !(f3 == 0 || f3 == 4); end
            default: ill = 1;
        endcase
        if (ill) begin imm = 0; cls = 6'h20; end
        else cls = {1'b0, cs, mm, mu, jp, br};
    endfunction

    task automatic compare_model(input string tag);
        logic [31:0] imm_e, imm_n;
        logic [5:0]  cls_e, cls_n;
        chk({tag, ":count"}, 32'(count), 32'(q.size()));
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ":count_nom"}, 32'(m_count), 32'(q.size()));
        if (q.size() != 0) begin
            ref_dec(q[0].inst, 1'b1, imm_e, cls_e);
            ref_dec(q[0].inst, 1'b0, imm_n, cls_n);
            chk({tag, ":out_pc"}, out_pc, q[0].pc);
            chk({tag, ":out_inst"}, out_inst, q[0].inst);
            chk({tag, ":out_imm"}, out_imm, imm_e);
            chk({tag, ":out_cls"}, 32'(out_cls), 32'(cls_e));
            chk({tag, ":out_cls_nom"}, 32'(m_out_cls), 32'(cls_n));
        end
    endtask

    // Called at a negedge; drives one cycle, updates model, checks.
    task automatic step(input string tag, input bit fl, input bit iv,
                        input bit ordy, input logic [31:0] pc,
                        input logic [31:0] inst);
        bit enq, deq;
        flush = fl; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_inst = inst;
        enq = iv && (q.size() < DEPTH) && !fl;
        deq = ordy && (q.size() != 0) && !fl;
        #1;
        chk({tag, ":in_ready"}, 32'(in_ready),
            32'((q.size() < DEPTH) && !fl));
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back('{pc: pc, inst: inst});
        end
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++)
            step(tag, 0, 0, 1, 0, 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0] ops [11];
        logic [6:0] f7s [4];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h73, 7'h00};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        f7s[3] = 7'($urandom);
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        if (r[6:0] == 7'h00) r[6:0] = 7'($urandom);
        r[31:25] = f7s[$urandom_range(0, 3)];
        return r;
    endfunction

    vec_t vt[16];

    initial begin
        vt = '{
            '{32'h00500093, 32'h00000005, 6'h00, 6'h00},
            '{32'hFE000EE3, 32'hFFFFFFFC, 6'h01, 6'h01},
            '{32'h02208033, 32'h00000000, 6'h04, 6'h20},
            '{32'h34202573, 32'h00000000, 6'h10, 6'h10},
            '{32'h008000EF, 32'h00000008, 6'h02, 6'h02},
            '{32'h00012083, 32'h00000000, 6'h08, 6'h08},
            '{32'h00112223, 32'h00000004, 6'h08, 6'h08},
            '{32'h4030D093, 32'h00000003, 6'h00, 6'h00},
            '{32'hFFFFFFFF, 32'h00000000, 6'h20, 6'h20},
            '{32'h40009093, 32'h00000000, 6'h20, 6'h20},
            '{32'h12345037, 32'h12345000, 6'h00, 6'h00},
            '{32'h00001067, 32'h00000000, 6'h20, 6'h20},
            '{32'h40000033, 32'h00000000, 6'h00, 6'h00},
            '{32'h40001033, 32'h00000000, 6'h20, 6'h20},
            '{32'h00000073, 32'h00000000, 6'h00, 6'h00},
            '{32'h3400D073, 32'h00000001, 6'h10, 6'h10}
        };

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:out_valid", 32'(out_valid), 0);
        chk("rst:count", 32'(count), 0);
        chk("rst:in_ready", 32'(in_ready), 0);
        chk("rst:out_pc", out_pc, 0);
        chk("rst:out_inst", out_inst, 0);
        chk("rst:out_imm", out_imm, 0);
        chk("rst:out_cls", 32'(out_cls), 0);
        rst_n = 1'b1;

        // First instruction appears one cycle after enqueue
        step("addi", 0, 1, 0, 32'h100, 32'h00500093);
        chk("addi:imm", out_imm, 5);
        chk("addi:cls", 32'(out_cls), 0);
        chk("addi:count", 32'(count), 1);
        drain("drain0");

        // Table-driven pre-decode vectors
        foreach (vt[k]) begin
            step("vec_push", 0, 1, 0, 32'h1000 + 32'(k * 4), vt[k].inst);
            chk($sformatf("vec%0d:imm", k), out_imm, vt[k].imm);
            chk($sformatf("vec%0d:cls", k), 32'(out_cls), 32'(vt[k].cls_m));
            chk($sformatf("vec%0d:cls_nom", k), 32'(m_out_cls),
                32'(vt[k].cls_nom));
            step("vec_pop", 0, 0, 1, 0, 0);
        end

        // Fill to full, extra push refused, drain in order
        for (int k = 0; k < DEPTH; k++)
            step("fill", 0, 1, 0, 32'h200 + 32'(k * 4), 32'h00100093 + 32'(k << 20));
        chk("full:count", 32'(count), DEPTH);
        chk("full:in_ready", 32'(in_ready), 0);
        step("push5", 0, 1, 0, 32'h300, 32'h00700093);
        chk("push5:count", 32'(count), DEPTH);

        // Full with push and pop in one cycle: dequeue only
        step("full_pp", 0, 1, 1, 32'h304, 32'h00800093);
        chk("full_pp:count", 32'(count), DEPTH - 1);
        drain("drain1");

        // Continuous traffic across pointer wrap
        step("stream0", 0, 1, 0, 32'h400, 32'h00000013);
        for (int k = 1; k <= 3 * DEPTH; k++)
            step("stream", 0, 1, 1, 32'h400 + 32'(k * 4), 32'h00000013 + 32'(k << 20));
        chk("stream:count", 32'(count), 1);
        drain("drain2");

        // Flush with three entries and a concurrent push
        for (int k = 0; k < 3; k++)
            step("pre_fl", 0, 1, 0, 32'h500 + 32'(k * 4), 32'h00300093);
        step("flush", 1, 1, 1, 32'h50C, 32'h00400093);
        chk("flush:out_valid", 32'(out_valid), 0);
        chk("flush:count", 32'(count), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++)
            step("rnd", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60), $urandom, rand_inst());

        // Reset in the middle of traffic
        for (int k = 0; k < 2; k++)
            step("pre_rst", 0, 1, 0, 32'h600 + 32'(k * 4), 32'h00900093);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        chk("mrst:out_valid", 32'(out_valid), 0);
        chk("mrst:count", 32'(count), 0);
        chk("mrst:in_ready", 32'(in_ready), 0);
        chk("mrst:out_pc", out_pc, 0);
        chk("mrst:out_inst", out_inst, 0);
        chk("mrst:out_imm", out_imm, 0);
        chk("mrst:out_cls", 32'(out_cls), 0);
        rst_n = 1'b1;
        step("post_rst", 0, 1, 0, 32'h700, 32'h00500093);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
